// File: rtl/ibex_trace_ctrl_pkg.sv
// Shared types for the retirement trace controller:
// FSM state encoding and the buffered trace record layout.
package ibex_trace_ctrl_pkg;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_TRACING = 2'd2,
    TR_STOPPED = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        drop;
  } trace_rec_t;

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Synchronous trace record FIFO with flush; read data is
// driven from storage and forced to zero while empty.
module ibex_trace_rec_fifo
  import ibex_trace_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t data_i,
  output trace_rec_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  trace_rec_t    r_mem [Depth];

  logic w_push;
  logic w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == FullCnt);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Payload storage needs no reset: empty gating hides stale slots.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/ibex_trace_ctrl.sv
// Retirement trace sequencer: PC start/stop triggers, record
// buffering with valid/ready output and drop accounting.
module ibex_trace_ctrl
  import ibex_trace_ctrl_pkg::*;
#(
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rvfi_valid,
  input  logic [63:0]             rvfi_order,
  input  logic [31:0]             rvfi_pc_rdata,
  input  logic [31:0]             rvfi_insn,
  input  logic                    rvfi_trap,
  input  logic                    cfg_en_i,
  input  logic                    cfg_start_en_i,
  input  logic [31:0]             cfg_start_pc_i,
  input  logic                    cfg_stop_en_i,
  input  logic [31:0]             cfg_stop_pc_i,
  input  logic                    cfg_clr_i,
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output logic [63:0]             trace_order_o,
  output logic [31:0]             trace_pc_o,
  output logic [31:0]             trace_insn_o,
  output logic                    trace_trap_o,
  output logic                    trace_drop_o,
  output logic [1:0]              state_o,
  output logic [DropCntWidth-1:0] drop_cnt_o,
  output logic                    overflow_o
);

  trace_state_e            r_state;
  trace_state_e            w_state_nxt;
  logic [DropCntWidth-1:0] r_drop_cnt;
  logic                    r_ovf;
  logic                    r_pend_drop;

  logic       w_start;
  logic       w_stop;
  logic       w_capture;
  logic       w_pop;
  logic       w_accept;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  trace_rec_t w_rec_in;
  trace_rec_t w_rec_out;

  assign w_start = rvfi_valid &
                   (~cfg_start_en_i | (rvfi_pc_rdata == cfg_start_pc_i));
  assign w_stop  = rvfi_valid & cfg_stop_en_i &
                   (rvfi_pc_rdata == cfg_stop_pc_i);

  assign w_capture = cfg_en_i & rvfi_valid &
                     ((r_state == TR_TRACING) |
                      ((r_state == TR_ARMED) & w_start));
  assign w_pop    = ~w_empty & trace_ready_i;
  assign w_accept = w_capture & (~w_full | w_pop);
  assign w_drop   = w_capture & ~w_accept;

  assign w_rec_in = '{
    order: rvfi_order,
    pc:    rvfi_pc_rdata,
    insn:  rvfi_insn,
    trap:  rvfi_trap,
    drop:  r_pend_drop
  };

  always_comb begin
    w_state_nxt = r_state;
    if (!cfg_en_i) begin
      w_state_nxt = TR_IDLE;
    end else begin
      unique case (r_state)
        TR_IDLE:    w_state_nxt = TR_ARMED;
        TR_ARMED:   if (w_start) w_state_nxt = w_stop ? TR_STOPPED : TR_TRACING;
        TR_TRACING: if (w_stop) w_state_nxt = TR_STOPPED;
        TR_STOPPED: w_state_nxt = TR_STOPPED;
        default:    w_state_nxt = TR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= TR_IDLE;
      r_drop_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_pend_drop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!cfg_en_i)     r_pend_drop <= 1'b0;
      else if (w_drop)   r_pend_drop <= 1'b1;
      else if (w_accept) r_pend_drop <= 1'b0;
      // A clear that meets a drop keeps that drop on record.
      if (cfg_clr_i) begin
        r_drop_cnt <= w_drop ? DropCntWidth'(1) : '0;
        r_ovf      <= w_drop;
      end else if (w_drop) begin
        if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
        r_ovf <= 1'b1;
      end
    end
  end

  ibex_trace_rec_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(~cfg_en_i),
    .push_i (w_accept),
    .pop_i  (w_pop),
    .data_i (w_rec_in),
    .data_o (w_rec_out),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  assign trace_valid_o = ~w_empty;
  assign trace_order_o = w_rec_out.order;
  assign trace_pc_o    = w_rec_out.pc;
  assign trace_insn_o  = w_rec_out.insn;
  assign trace_trap_o  = w_rec_out.trap;
  assign trace_drop_o  = w_rec_out.drop;
  assign state_o       = r_state;
  assign drop_cnt_o    = r_drop_cnt;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_ibex_trace_ctrl.sv
// Directed bench for ibex_trace_ctrl: inputs change and outputs
// are sampled on the falling clock edge.
module tb_ibex_trace_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_pc;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        cfg_en;
  logic        cfg_start_en;
  logic [31:0] cfg_start_pc;
  logic        cfg_stop_en;
  logic [31:0] cfg_stop_pc;
  logic        cfg_clr;
  logic        t_valid;
  logic        t_ready;
  logic [63:0] t_order;
  logic [31:0] t_pc;
  logic [31:0] t_insn;
  logic        t_trap;
  logic        t_drop;
  logic [1:0]  state;
  logic [15:0] drop_cnt;
  logic        ovf;

  int n_chk;
  int n_pass;
  logic [63:0] ord;

  ibex_trace_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_pc_rdata (rvfi_pc),
    .rvfi_insn     (rvfi_insn),
    .rvfi_trap     (rvfi_trap),
    .cfg_en_i      (cfg_en),
    .cfg_start_en_i(cfg_start_en),
    .cfg_start_pc_i(cfg_start_pc),
    .cfg_stop_en_i (cfg_stop_en),
    .cfg_stop_pc_i (cfg_stop_pc),
    .cfg_clr_i     (cfg_clr),
    .trace_valid_o (t_valid),
    .trace_ready_i (t_ready),
    .trace_order_o (t_order),
    .trace_pc_o    (t_pc),
    .trace_insn_o  (t_insn),
    .trace_trap_o  (t_trap),
    .trace_drop_o  (t_drop),
    .state_o       (state),
    .drop_cnt_o    (drop_cnt),
    .overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic retire(input logic [31:0] pc);
    rvfi_valid = 1'b1;
    rvfi_pc    = pc;
    rvfi_insn  = pc ^ 32'h0000_0013;
    rvfi_order = ord;
    ord        = ord + 64'd1;
    step();
    rvfi_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (t_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", t_valid); else n_pass++;
    n_chk++; if (state !== 2'd0) $display("FAIL rst_state got %0d exp 0", state); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", drop_cnt); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf); else n_pass++;
    n_chk++; if ({t_order, t_pc, t_insn, t_trap, t_drop} !== '0) $display("FAIL rst_fields got %h exp 0", t_pc); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    cfg_en = 1'b1; cfg_start_en = 1'b0; cfg_stop_en = 1'b0; t_ready = 1'b1;
    step();
    n_chk++; if (state !== 2'd1) $display("FAIL fr_armed got %0d exp 1", state); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      retire(pcs[i]);
      n_chk++; if (t_valid !== 1'b1) $display("FAIL fr_valid%0d got %b exp 1", i, t_valid); else n_pass++;
      n_chk++; if (t_pc !== pcs[i]) $display("FAIL fr_pc%0d got %h exp %h", i, t_pc, pcs[i]); else n_pass++;
      n_chk++; if (t_order !== 64'(i)) $display("FAIL fr_order%0d got %0d exp %0d", i, t_order, i); else n_pass++;
    end
    n_chk++; if (t_insn !== 32'h11b) $display("FAIL fr_insn got %h exp 11b", t_insn); else n_pass++;
    n_chk++; if (state !== 2'd2) $display("FAIL fr_state got %0d exp 2", state); else n_pass++;
    step();
    n_chk++; if (t_valid !== 1'b0) $display("FAIL fr_drain got %b exp 0", t_valid); else n_pass++;
  endtask

  task automatic test_window();
    logic [31:0] exp_pc [4];
    int n;
    exp_pc[0] = 32'h200; exp_pc[1] = 32'h204;
    exp_pc[2] = 32'h208; exp_pc[3] = 32'h20C;
    n = 0;
    cfg_en = 1'b0;
    step();
    cfg_start_en = 1'b1; cfg_start_pc = 32'h200;
    cfg_stop_en  = 1'b1; cfg_stop_pc  = 32'h20C;
    cfg_en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      retire(32'h1FC + 32'(4 * i));
      if (t_valid) begin
        n_chk++;
        if (n > 3 || t_pc !== exp_pc[n > 3 ? 3 : n])
          $display("FAIL win_rec%0d got %h exp %h", n, t_pc, exp_pc[n > 3 ? 3 : n]);
        else n_pass++;
        n++;
      end
    end
    n_chk++; if (n !== 4) $display("FAIL win_count got %0d exp 4", n); else n_pass++;
    n_chk++; if (state !== 2'd3) $display("FAIL win_state got %0d exp 3", state); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc [3];
    logic        exp_dr [3];
    exp_pc[0] = 32'h308; exp_pc[1] = 32'h30C; exp_pc[2] = 32'h318;
    exp_dr[0] = 1'b0;    exp_dr[1] = 1'b0;    exp_dr[2] = 1'b1;
    cfg_en = 1'b0;
    step();
    cfg_start_en = 1'b0; cfg_stop_en = 1'b0; cfg_en = 1'b1;
    step();
    t_ready = 1'b0;
    for (int i = 0; i < 6; i++) retire(32'h300 + 32'(4 * i));
    n_chk++; if (drop_cnt !== 16'd2) $display("FAIL ov_cnt got %0d exp 2", drop_cnt); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL ov_flag got %b exp 1", ovf); else n_pass++;
    n_chk++; if (t_pc !== 32'h300 || t_drop !== 1'b0) $display("FAIL ov_head got %h/%b exp 300/0", t_pc, t_drop); else n_pass++;
    t_ready = 1'b1;
    retire(32'h318);
    n_chk++; if (drop_cnt !== 16'd2) $display("FAIL fp_cnt got %0d exp 2", drop_cnt); else n_pass++;
    n_chk++; if (t_pc !== 32'h304 || t_drop !== 1'b0) $display("FAIL fp_head got %h/%b exp 304/0", t_pc, t_drop); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (t_valid !== 1'b1 || t_pc !== exp_pc[i] || t_drop !== exp_dr[i])
        $display("FAIL ov_drain%0d got %b/%h/%b exp 1/%h/%b", i, t_valid, t_pc, t_drop, exp_pc[i], exp_dr[i]);
      else n_pass++;
    end
    step();
    n_chk++; if (t_valid !== 1'b0) $display("FAIL ov_empty got %b exp 0", t_valid); else n_pass++;
  endtask

  task automatic test_disable();
    t_ready = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h400 + 32'(4 * i));
    n_chk++; if (t_valid !== 1'b1 || t_pc !== 32'h400) $display("FAIL dis_pre got %b/%h exp 1/400", t_valid, t_pc); else n_pass++;
    cfg_en = 1'b0;
    retire(32'h40C);
    n_chk++; if (t_valid !== 1'b0) $display("FAIL dis_valid got %b exp 0", t_valid); else n_pass++;
    n_chk++; if (state !== 2'd0) $display("FAIL dis_state got %0d exp 0", state); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd2 || ovf !== 1'b1) $display("FAIL dis_keep got %0d/%b exp 2/1", drop_cnt, ovf); else n_pass++;
    cfg_en = 1'b1;
    step();
    n_chk++; if (state !== 2'd1 || t_valid !== 1'b0) $display("FAIL dis_rearm got %0d/%b exp 1/0", state, t_valid); else n_pass++;
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    n_chk++; if (drop_cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL clr got %0d/%b exp 0/0", drop_cnt, ovf); else n_pass++;
  endtask

  task automatic test_clr_with_drop();
    for (int i = 0; i < 5; i++) retire(32'h500 + 32'(4 * i));
    n_chk++; if (drop_cnt !== 16'd1) $display("FAIL cd_pre got %0d exp 1", drop_cnt); else n_pass++;
    cfg_clr = 1'b1;
    retire(32'h514);
    cfg_clr = 1'b0;
    n_chk++; if (drop_cnt !== 16'd1 || ovf !== 1'b1) $display("FAIL cd_post got %0d/%b exp 1/1", drop_cnt, ovf); else n_pass++;
  endtask

  task automatic test_async_reset();
    n_chk++; if (t_valid !== 1'b1) $display("FAIL ar_pre got %b exp 1", t_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (t_valid !== 1'b0 || state !== 2'd0) $display("FAIL ar_vs got %b/%0d exp 0/0", t_valid, state); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL ar_cnt got %0d/%b exp 0/0", drop_cnt, ovf); else n_pass++;
    n_chk++; if (t_pc !== 32'd0 || t_order !== 64'd0) $display("FAIL ar_fields got %h/%0d exp 0/0", t_pc, t_order); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; ord = 64'd0;
    rst_n = 1'b0; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_pc = '0;
    rvfi_insn = '0; rvfi_trap = 1'b0; cfg_en = 1'b0; cfg_start_en = 1'b0;
    cfg_start_pc = '0; cfg_stop_en = 1'b0; cfg_stop_pc = '0;
    cfg_clr = 1'b0; t_ready = 1'b0;
    test_reset();
    test_free_run();
    test_window();
    test_overflow();
    test_disable();
    test_clr_with_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_trace_ctrl.md
Name: ibex_trace_ctrl

Overview:
- Sequences the retirement trace stream between the core's RVFI outputs and a trace sink.
- Arms tracing from config, starts and stops capture on programmable PC triggers, and buffers captured records in a small FIFO with a valid/ready output handshake.
- Counts and flags records dropped on overflow.
- Sits beside the tracer in the tracing top level, fed by the same RVFI signals.

Parameters:
- FifoDepth, 4, number of record slots; power of two, >=2.
- DropCntWidth, 16, width of the saturating dropped-record counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- rvfi_valid  in  1  retirement strobe.
- rvfi_order  in  64  retirement index.
- rvfi_pc_rdata  in  32  PC of retired instruction.
- rvfi_insn  in  32  retired instruction word.
- rvfi_trap  in  1  retirement trapped.
- cfg_en_i  in  1  level; 0 forces IDLE and flushes.
- cfg_start_en_i  in  1  1 = wait for start PC match; 0 = start on first retirement.
- cfg_start_pc_i  in  32  start trigger PC.
- cfg_stop_en_i  in  1  enable stop trigger.
- cfg_stop_pc_i  in  32  stop trigger PC.
- cfg_clr_i  in  1  pulse; clears drop counter and overflow sticky.
- trace_valid_o  out  1  record available.
- trace_ready_i  in  1  sink accepts.
- trace_order_o  out  64  record order.
- trace_pc_o  out  32  record PC.
- trace_insn_o  out  32  record instruction.
- trace_trap_o  out  1  record trap flag.
- trace_drop_o  out  1  one or more records were lost immediately before this record.
- state_o  out  2  current FSM state.
- drop_cnt_o  out  DropCntWidth  dropped records, saturating.
- overflow_o  out  1  sticky; set on any drop.

Behaviour:
- Reset values: state IDLE, FIFO empty, all trace_* outputs 0, drop_cnt_o 0, overflow_o 0, pending-drop flag 0.
- FSM states and encoding: IDLE=0, ARMED=1, TRACING=2, STOPPED=3.
  - IDLE -> ARMED when cfg_en_i=1.
  - ARMED -> TRACING on a retirement with start match.
  - TRACING -> STOPPED on a retirement with stop match.
  - Any state -> IDLE when cfg_en_i=0; this has priority over every other transition.
  - STOPPED persists until cfg_en_i drops.
- Match definitions:
  - start match = rvfi_valid & (!cfg_start_en_i | rvfi_pc_rdata==cfg_start_pc_i).
  - stop match = rvfi_valid & cfg_stop_en_i & rvfi_pc_rdata==cfg_stop_pc_i.
- Capture: a retirement is captured when it occurs in TRACING, or when it is the start-match retirement in ARMED.
- Stop-match record: included. If one retirement matches both start and stop in ARMED, it is captured and the FSM goes directly to STOPPED.
- Push rule: a capture is accepted if the FIFO is not full, or if a pop occurs in the same cycle (trace_valid_o & trace_ready_i). Simultaneous push and pop leaves the occupancy unchanged.
- Latency: a record captured in cycle N is visible on trace_valid_o in cycle N+1 when the FIFO was empty. Outputs come from registered storage with no combinational path from rvfi_* to trace_*.
- Handshake: once asserted, trace_valid_o and the record fields stay stable until trace_ready_i. FIFO order is strict; pointers wrap modulo FifoDepth.
- Overflow on a capture that cannot be accepted:
  - The record is discarded, overflow_o is set, drop_cnt_o increments (saturating at all-ones), and the pending-drop flag is set.
  - The next accepted record carries trace_drop_o=1, and the pending-drop flag then clears.
- cfg_clr_i: if it coincides with a drop, drop_cnt_o becomes 1 and overflow_o stays 1. cfg_clr_i does not affect the FIFO or the FSM.
- cfg_en_i=0 mid-operation: the FIFO is flushed (trace_valid_o=0 next cycle) and the pending-drop flag clears. drop_cnt_o and overflow_o are retained. Any retirement in that cycle is ignored.
- Asynchronous reset mid-operation: all state returns immediately to the reset values.

Decomposition:
- ibex_pkg additions:
  - trace_state_e (2-bit enum for the FSM states).
  - trace_rec_t (packed struct: order, pc, insn, trap, drop).
- Sub-module ibex_trace_rec_fifo: a parameterised synchronous FIFO of trace_rec_t with push/pop/full/empty/flush. The FSM, trigger logic and counter stay in the top-level block.

Test Plan:
- Free run: cfg_en=1, start_en=0, stop_en=0, ready=1; retire 3 instructions at PCs 0x100, 0x104, 0x108 -> three records in order, each valid one cycle after its retirement; state_o=2.
- Start/stop window: start_pc=0x200, stop_pc=0x20C; retire PCs 0x1FC..0x210 -> only 0x200..0x20C emitted (4 records); state_o=3; 0x210 not emitted.
- Overflow: FifoDepth=4, ready=0; 6 retirements in TRACING -> 4 buffered, drop_cnt_o=2, overflow_o=1. Raise ready and retire one more -> 5th record out has trace_drop_o=1, earlier records have 0.
- Full with simultaneous pop: FIFO full, ready=1 and a retirement in the same cycle -> record accepted, occupancy stays 4, drop_cnt_o unchanged.
- Disable mid-trace: 3 records buffered, cfg_en=0 for one cycle -> trace_valid_o=0 next cycle, state_o=0, drop_cnt_o retained. cfg_clr_i pulse -> drop_cnt_o=0, overflow_o=0.
- Reset mid-operation: assert rst_ni=0 asynchronously with records buffered -> all outputs 0 without waiting for a clock edge.
